// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit period plus the TX and RX state encodings.
// The CLKS_PER_BIT define is the shared parameter default used by both directions.
`ifndef CLKS_PER_BIT
`define CLKS_PER_BIT 4
`endif

package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'b00,
        TX_START = 2'b01,
        TX_DATA  = 2'b10,
        TX_STOP  = 2'b11
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'b000,
        RX_START   = 3'b001,
        RX_DATA    = 3'b010,
        RX_STOP    = 3'b011,
        RX_CLEANUP = 3'b100
    } rx_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam logic [2:0]  LAST_DATA_BIT = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer: power-of-two circular FIFO with registered full/empty/count.
// Writes while full are dropped even when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_Clock,
    input  logic                     i_Rst_L,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [PTR_W:0]   count_next;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == COUNT_FULL);
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: FIFO feeds a start/data/stop FSM with a bit-period counter.
// Back-to-back frames are sent with no idle cycle while bytes remain buffered.
`ifndef CLKS_PER_BIT
`define CLKS_PER_BIT 4
`endif

module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = `CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_L,
    input  logic                          i_TX_DV,
    input  logic [7:0]                    i_TX_Byte,
    output logic                          o_TX_Ready,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Active,
    output logic                          o_TX_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

    tx_state_e        state;
    logic [CNT_W-1:0] clk_count;
    logic [2:0]       bit_index;
    logic [7:0]       shift;
    logic             bit_end;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Rst_L (i_Rst_L),
        .push    (i_TX_DV),
        .pop     (fifo_pop),
        .din     (i_TX_Byte),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (o_FIFO_Count)
    );

    assign o_TX_Ready = ~fifo_full;
    assign bit_end    = (clk_count == BIT_LAST);

    // Pop from idle, or at the end of a stop bit to chain the next frame without a gap.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (state == TX_IDLE) begin
                fifo_pop = 1'b1;
            end else if (state == TX_STOP && bit_end) begin
                fifo_pop = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= TX_IDLE;
            clk_count   <= '0;
            bit_index   <= '0;
            shift       <= '0;
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;
        end else begin
            o_TX_Done <= 1'b0;
            case (state)
                TX_IDLE: begin
                    o_TX_Serial <= 1'b1;
                    o_TX_Active <= 1'b0;
                    clk_count   <= '0;
                    bit_index   <= '0;
                    if (fifo_pop) begin
                        shift       <= fifo_dout;
                        state       <= TX_START;
                        o_TX_Serial <= 1'b0;
                        o_TX_Active <= 1'b1;
                    end
                end

                TX_START: begin
                    if (bit_end) begin
                        clk_count   <= '0;
                        bit_index   <= '0;
                        state       <= TX_DATA;
                        o_TX_Serial <= shift[0];
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                TX_DATA: begin
                    if (bit_end) begin
                        clk_count <= '0;
                        if (bit_index == LAST_DATA_BIT) begin
                            bit_index   <= '0;
                            state       <= TX_STOP;
                            o_TX_Serial <= 1'b1;
                        end else begin
                            bit_index   <= bit_index + 1'b1;
                            shift       <= {1'b0, shift[7:1]};
                            o_TX_Serial <= shift[1];
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                TX_STOP: begin
                    // Raise Done one cycle early so the registered pulse lands on the last stop cycle.
                    o_TX_Done <= (clk_count == BIT_PRE_LAST);
                    if (bit_end) begin
                        clk_count <= '0;
                        if (fifo_pop) begin
                            shift       <= fifo_dout;
                            state       <= TX_START;
                            o_TX_Serial <= 1'b0;
                        end else begin
                            state       <= TX_IDLE;
                            o_TX_Serial <= 1'b1;
                            o_TX_Active <= 1'b0;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                default: begin
                    state       <= TX_IDLE;
                    clk_count   <= '0;
                    bit_index   <= '0;
                    o_TX_Serial <= 1'b1;
                    o_TX_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level reference model, serial-line decoder and directed/random stimulus.
// The model tracks a byte queue and the position within the current 10-bit frame.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic       clk     = 1'b0;
    logic       rst_l   = 1'b1;
    logic       tx_dv   = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       ready;
    logic       serial;
    logic       active;
    logic       done;
    logic [3:0] fcount;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] exp_rx[$];
    logic [7:0] cur = 8'h00;
    int         fpos = -1;

    // Observation counters
    logic [7:0] rx_log[$];
    int done_cnt = 0;
    int act_cnt  = 0;
    int act_rise = 0;
    logic prev_active = 1'b0;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_Clock      (clk),
        .i_Rst_L      (rst_l),
        .i_TX_DV      (tx_dv),
        .i_TX_Byte    (tx_byte),
        .o_TX_Ready   (ready),
        .o_TX_Serial  (serial),
        .o_TX_Active  (active),
        .o_TX_Done    (done),
        .o_FIFO_Count (fcount)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_serial();
        int b;
        if (fpos < 0) return 1'b1;
        b = fpos / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return cur[b-1];
    endfunction

    // Model: one frame = FRAME cycles; pop when idle or on the last frame cycle.
    initial begin
        forever begin
            @(posedge clk or negedge rst_l);
            if (!rst_l) begin
                q.delete();
                exp_rx.delete();
                fpos = -1;
            end else begin
                bit acc;
                bit pop;
                acc = tx_dv && (q.size() < DEPTH);
                pop = (fpos < 0 || fpos == FRAME - 1) && (q.size() > 0);
                if (pop) begin
                    cur = q.pop_front();
                    exp_rx.push_back(cur);
                    fpos = 0;
                end else if (fpos == FRAME - 1) begin
                    fpos = -1;
                end else if (fpos >= 0) begin
                    fpos++;
                end
                if (acc) q.push_back(tx_byte);
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        wait (started);
        forever begin
            @(negedge clk);
            check("serial", 32'(serial), 32'(model_serial()));
            check("active", 32'(active), 32'(fpos >= 0));
            check("done",   32'(done),   32'(fpos == FRAME - 1));
            check("count",  32'(fcount), 32'(q.size()));
            check("ready",  32'(ready),  32'(q.size() < DEPTH));
            if (done === 1'b1) done_cnt++;
            if (active === 1'b1) act_cnt++;
            if (active === 1'b1 && prev_active !== 1'b1) act_rise++;
            prev_active = active;
        end
    end

    // Independent line decoder: samples mid-bit, checks bytes in write order
    initial begin
        int dpos;
        int bidx;
        logic [7:0] dbyte;
        logic [7:0] want;
        dpos = -1;
        dbyte = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_l || !started) begin
                dpos = -1;
            end else begin
                if (dpos < 0) begin
                    if (serial === 1'b0) dpos = 0;
                end else begin
                    dpos++;
                end
                if (dpos >= 0 && (dpos % CPB) == CPB / 2) begin
                    bidx = dpos / CPB;
                    if (bidx == 0) begin
                        check("rx_start", 32'(serial), 32'd0);
                    end else if (bidx <= 8) begin
                        dbyte[bidx-1] = serial;
                    end else begin
                        check("rx_stop", 32'(serial), 32'd1);
                        rx_log.push_back(dbyte);
                        if (exp_rx.size() == 0) begin
                            check("rx_extra", 32'd1, 32'd0);
                        end else begin
                            want = exp_rx.pop_front();
                            check("rx_byte", 32'(dbyte), 32'(want));
                        end
                        dpos = -1;
                    end
                end
            end
        end
    end

    task automatic wait_drain(input string name, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (fpos < 0 && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic write_burst(input logic [7:0] bytes[$]);
        foreach (bytes[i]) begin
            @(negedge clk);
            tx_dv   = 1'b1;
            tx_byte = bytes[i];
        end
        @(negedge clk);
        tx_dv = 1'b0;
    endtask

    initial begin
        int d0;
        int a0;
        int r0;
        bit found;
        logic [9:0] pat;
        logic [7:0] burst[$];

        // Reset
        #3 rst_l = 1'b0;
        started = 1'b1;
        #1;
        check("rst_serial", 32'(serial), 32'd1);
        check("rst_ready",  32'(ready),  32'd1);
        check("rst_count",  32'(fcount), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_l = 1'b1;
        @(negedge clk);
        check("post_rst_active", 32'(active), 32'd0);
        check("post_rst_done",   32'(done),   32'd0);

        // Idle for 100 cycles
        d0 = done_cnt;
        repeat (100) @(negedge clk);
        check("idle_done",   32'(done_cnt - d0), 32'd0);
        check("idle_serial", 32'(serial), 32'd1);
        check("idle_ready",  32'(ready),  32'd1);

        // Single byte 0x35 with literal waveform
        d0 = done_cnt;
        a0 = act_cnt;
        pat = {1'b1, 8'h35, 1'b0};
        @(negedge clk);
        tx_dv   = 1'b1;
        tx_byte = 8'h35;
        @(negedge clk);
        tx_dv = 1'b0;
        check("lat_n1", 32'(serial), 32'd1);
        for (int k = 0; k <= FRAME; k++) begin
            @(negedge clk);
            if (k < FRAME) check("wave35", 32'(serial), 32'(pat[k / CPB]));
            else           check("wave35_idle", 32'(serial), 32'd1);
        end
        check("done35", 32'(done_cnt - d0), 32'd1);
        check("act35",  32'(act_cnt - a0),  32'(FRAME));

        // Back-to-back A5, 00, FF
        repeat (5) @(negedge clk);
        rx_log.delete();
        d0 = done_cnt;
        a0 = act_cnt;
        r0 = act_rise;
        burst = '{8'hA5, 8'h00, 8'hFF};
        write_burst(burst);
        wait_drain("b2b_drain", 300);
        check("b2b_done", 32'(done_cnt - d0), 32'd3);
        check("b2b_act",  32'(act_cnt - a0),  32'(3 * FRAME));
        check("b2b_rise", 32'(act_rise - r0), 32'd1);
        check("b2b_n", 32'(rx_log.size()), 32'd3);
        if (rx_log.size() == 3) begin
            check("b2b_0", 32'(rx_log[0]), 32'hA5);
            check("b2b_1", 32'(rx_log[1]), 32'h00);
            check("b2b_2", 32'(rx_log[2]), 32'hFF);
        end

        // Ten consecutive writes into depth 8: one in flight, eight buffered, one dropped
        rx_log.delete();
        burst.delete();
        for (int i = 0; i < 10; i++) burst.push_back(8'(8'h10 + i));
        write_burst(burst);
        check("ovf_count", 32'(fcount), 32'd8);
        check("ovf_ready", 32'(ready),  32'd0);

        // Full + write + pop in the same cycle
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (fpos == FRAME - 1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("fwp_found", 32'(found), 32'd1);
        check("fwp_pre", 32'(fcount), 32'd8);
        tx_dv   = 1'b1;
        tx_byte = 8'hEE;
        @(negedge clk);
        tx_dv = 1'b0;
        check("fwp_post", 32'(fcount), 32'd7);
        wait_drain("ovf_drain", 12 * FRAME);
        check("ovf_n", 32'(rx_log.size()), 32'd9);
        for (int i = 0; i < 9 && i < rx_log.size(); i++) begin
            check("ovf_order", 32'(rx_log[i]), 32'(8'h10 + i));
        end

        // Reset during data bit 3 with two bytes queued
        rx_log.delete();
        burst = '{8'h5A, 8'hC3, 8'h3C};
        write_burst(burst);
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(posedge clk);
            #2;
            if (fpos == 4 * CPB + 1) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_found", 32'(found), 32'd1);
        check("mid_serial_pre", 32'(serial), 32'(model_serial()));
        rst_l = 1'b0;
        #1;
        check("mid_serial", 32'(serial), 32'd1);
        check("mid_count",  32'(fcount), 32'd0);
        check("mid_active", 32'(active), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_l = 1'b1;
        d0 = done_cnt;
        a0 = act_cnt;
        repeat (200) @(negedge clk);
        check("mid_no_done",  32'(done_cnt - d0), 32'd0);
        check("mid_no_act",   32'(act_cnt - a0),  32'd0);
        check("mid_no_bytes", 32'(rx_log.size()), 32'd0);

        // Randomized traffic, heavy enough to hit full
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            tx_dv   = ($urandom_range(0, 3) != 0) && ($urandom_range(0, 99) < 60);
            tx_byte = 8'($urandom);
            if ((i % 150) > 120) tx_dv = 1'b0;
        end
        @(negedge clk);
        tx_dv = 1'b0;
        wait_drain("rand_drain", 12 * FRAME);
        check("rand_rx_left", 32'(exp_rx.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default `CLKS_PER_BIT from the shared parameter file: i_Clock cycles per serial bit, minimum 2.
REQ-002 Parameter FIFO_DEPTH, default 8: number of transmit byte slots; power of two, minimum 2.
REQ-003 i_Clock  input  1  system clock; all logic on the rising edge.
REQ-004 i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-005 i_TX_DV  input  1  write strobe; i_TX_Byte is accepted on a cycle where i_TX_DV=1 and o_TX_Ready=1.
REQ-006 i_TX_Byte  input  8  byte to transmit.
REQ-007 o_TX_Ready  output  1  high when the FIFO is not full (registered).
REQ-008 o_TX_Serial  output  1  UART line; idle high, 8N1, LSB first.
REQ-009 o_TX_Active  output  1  high from the first start-bit cycle to the last stop-bit cycle of every frame.
REQ-010 o_TX_Done  output  1  one-cycle pulse on the last stop-bit cycle of each frame.
REQ-011 o_FIFO_Count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered; excludes the frame in flight.

Function
REQ-012 Frame format SHALL be 1 start bit (0), 8 data bits (LSB first), 1 stop bit (1), no parity; each bit SHALL be held for exactly CLKS_PER_BIT cycles.
REQ-013 The state machine SHALL have the states IDLE, START, DATA and STOP; any unused encoding SHALL go to IDLE with o_TX_Serial=1.
REQ-014 IDLE: o_TX_Serial=1 and o_TX_Active=0; if the FIFO is non-empty, the block SHALL pop one byte into the shift register and go to START.
REQ-015 Latency: a byte written into an empty FIFO with the block in IDLE on cycle N SHALL drive o_TX_Serial low starting at cycle N+2.
REQ-016 START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with the bit index at 0.
REQ-017 DATA: hold bit[index] for CLKS_PER_BIT cycles; advance the index 0..7; after bit 7, go to STOP.
REQ-018 STOP: hold 1 for CLKS_PER_BIT cycles; assert o_TX_Done on the last cycle.
REQ-019 At the end of STOP with the FIFO non-empty, the block SHALL pop and go directly to START, with no idle cycle between frames.
REQ-020 At the end of STOP with the FIFO empty, the block SHALL go to IDLE.
REQ-021 A write while the FIFO is full (o_TX_Ready=0) SHALL be dropped without corrupting stored data; a same-cycle pop does not make the write succeed.
REQ-022 A simultaneous accepted write and pop SHALL leave o_FIFO_Count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 Bytes SHALL be transmitted in write order.
REQ-024 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL count 0..CLKS_PER_BIT-1.
REQ-025 o_TX_Serial SHALL come directly from a flop (glitch-free).

Reset
REQ-026 When i_Rst_L=0, the block SHALL asynchronously force: state IDLE, o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, FIFO empty, o_FIFO_Count=0, o_TX_Ready=1, counters 0.
REQ-027 A reset mid-frame SHALL abort the frame immediately; after release, no partial frame or buffered byte SHALL be sent.
REQ-028 FIFO storage contents need no reset.

Structure
REQ-029 CLKS_PER_BIT SHALL come from the shared parameter file, and the TX state encoding SHALL live in a shared package uart_pkg alongside the RX states.
REQ-030 The buffer SHALL be a sub-module uart_tx_fifo with ports push, pop, din, dout, full, empty and count.
REQ-031 The top level SHALL hold the FSM, the bit counter and the shift register.

Verification
REQ-032 CLKS_PER_BIT=4: write 0x35 once -> o_TX_Serial low at N+2, then data bits 1,0,1,0,1,1,0,0 each 4 cycles, then 1; o_TX_Done pulses once; the line is 40 cycles low-to-idle.
REQ-033 Write 0xA5, 0x00, 0xFF back-to-back -> three contiguous 40-cycle frames with no gap; three o_TX_Done pulses; a looped-back uart_rx reports A5, 00, FF.
REQ-034 Write 10 bytes on consecutive cycles with FIFO_DEPTH=8 while the first frame is starting -> byte 1 in flight, bytes 2-9 buffered, o_TX_Ready=0, byte 10 dropped; exactly 9 frames in order.
REQ-035 FIFO full plus write plus pop in the same cycle -> the write is dropped and o_FIFO_Count goes 8->7.
REQ-036 Assert i_Rst_L=0 during data bit 3 of a frame with 2 bytes queued -> o_TX_Serial=1 at once, o_FIFO_Count=0, no frame after release.
REQ-037 Idle for 100 cycles after reset -> o_TX_Serial stays 1, o_TX_Ready=1, o_TX_Done never pulses.
